// File: rtl/aes_sbox_engine.sv
// Iterative AES SubBytes / InvSubBytes over one NBYTES state, LANES S-box lookups per cycle.
// Latency: accept at edge T -> out_valid after edge T+NBYTES/LANES; back-to-back accept from DONE.
// Backpressure: result held in DONE until out_ready; in_ready follows out_ready there; flush aborts.
module aes_sbox_engine #(
    parameter int NBYTES = 16,
    parameter int LANES  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_inv,
    input  logic [0:8*NBYTES-1] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [0:8*NBYTES-1] out_data,
    output logic                busy
);
    localparam int W  = 8 * NBYTES;
    localparam int CW = $clog2(NBYTES + 1);
    localparam logic [CW-1:0] LAST = CW'(NBYTES - LANES);
    localparam logic [CW-1:0] STEP = CW'(LANES);

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16) ||
            (NBYTES % LANES) != 0) begin : g_bad_cfg
            $error("aes_sbox_engine: LANES must be 1/2/4/8/16 and divide NBYTES");
        end
    endgenerate

    // GF(2^8) arithmetic, reduction polynomial x^8+x^4+x^3+x+1
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 = a^-1 for a != 0, and maps 0 to 0 as SubBytes requires
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = a;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] sub_byte(input logic [7:0] b, input logic inv);
        logic [7:0] t;
        logic [7:0] s;
        if (inv) begin
            t = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
            s = gf_inv(t);
        end else begin
            t = gf_inv(b);
            s = t ^ {t[6:0], t[7]} ^ {t[5:0], t[7:6]} ^ {t[4:0], t[7:5]} ^ {t[3:0], t[7:4]} ^ 8'h63;
        end
        return s;
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [0:W-1]    st_q, st_d;
    logic            mode_q;
    logic [CW-1:0]   cnt_q;
    logic            accept;
    logic            last;

    assign last     = (cnt_q == LAST);
    assign accept   = in_valid && in_ready;
    assign out_data = st_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE: begin
                busy     = 1'b0;
                in_ready = !flush;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                if (last) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready && !flush;
                if (out_ready) state_d = in_valid ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    // cnt_q is always a multiple of LANES, so the lane window never straddles the state end
    always_comb begin
        st_d = st_q;
        for (int l = 0; l < LANES; l++) begin
            st_d[8*(int'(cnt_q)+l) +: 8] = sub_byte(st_q[8*(int'(cnt_q)+l) +: 8], mode_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= '0;
            mode_q <= 1'b0;
            cnt_q  <= '0;
        end else if (flush) begin
            cnt_q <= '0;
        end else if (accept) begin
            st_q   <= in_data;
            mode_q <= in_inv;
            cnt_q  <= '0;
        end else if (state_q == RUN) begin
            st_q  <= st_d;
            cnt_q <= last ? '0 : cnt_q + STEP;
        end
    end

endmodule

// File: tb/tb_aes_sbox_engine.sv
// Bench for aes_sbox_engine: transaction model built from a searched GF inverse and the bitwise affine map.
module tb_aes_sbox_engine;
    localparam int NB = 16;
    localparam int LN = 4;
    localparam int NL = NB / LN;

    logic         clk = 1'b0;
    logic         rst_n, flush, in_valid, in_ready, in_inv, out_valid, out_ready, busy;
    logic [127:0] in_data, out_data;
    int           checks = 0;
    int           errors = 0;
    int           gen_done = 0;
    bit           cmp_en = 1'b0;
    logic [7:0]   fsb [256];
    logic [7:0]   isb [256];

    always #5 clk = ~clk;

    aes_sbox_engine #(.NBYTES(NB), .LANES(LN)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_inv(in_inv), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    task automatic build_tables();
        logic [7:0] b, s, c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            b = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ c[i];
            fsb[x] = s;
            isb[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] subst(input logic [127:0] d, input bit inv);
        logic [127:0] r;
        for (int k = 0; k < 16; k++)
            r[8*k +: 8] = inv ? isb[d[8*k +: 8]] : fsb[d[8*k +: 8]];
        return r;
    endfunction

    // Transaction-level model: a pending state finishes NL edges after accept
    int           m_rem = 0;
    bit           m_done = 1'b0;
    bit           m_known = 1'b1;
    logic [127:0] m_res = '0;
    logic [127:0] m_last = '0;

    initial begin : model
        bit idle, acc;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_rem = 0; m_done = 1'b0; m_known = 1'b1; m_last = '0;
            end else if (flush) begin
                m_rem = 0; m_done = 1'b0; m_known = 1'b0;
            end else begin
                idle = (m_rem == 0) && !m_done;
                acc  = in_valid && (idle || (m_done && out_ready));
                if (m_rem > 0) begin
                    m_rem--;
                    if (m_rem == 0) begin
                        m_done = 1'b1; m_last = m_res; m_known = 1'b1;
                    end
                end else if (m_done && out_ready) begin
                    m_done = 1'b0;
                end
                if (acc) begin
                    m_res = subst(in_data, in_inv); m_rem = NL; m_done = 1'b0;
                end
            end
        end
    end

    initial begin : compare
        bit idle;
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                idle = (m_rem == 0) && !m_done;
                chk("cmp_in_ready", 128'(in_ready), 128'(!flush && (idle || (m_done && out_ready))));
                chk("cmp_out_valid", 128'(out_valid), 128'(m_done));
                chk("cmp_busy", 128'(busy), 128'(!idle));
                if (m_done || (idle && m_known)) chk("cmp_out_data", out_data, m_last);
            end
        end
    end

    task automatic send(input logic [127:0] d, input logic inv);
        bit r, ok;
        ok = 1'b0;
        in_valid = 1'b1; in_data = d; in_inv = inv;
        for (int t = 0; t < 64 && !ok; t++) begin
            @(negedge clk); r = in_ready;
            @(posedge clk); ok = r;
        end
        chk("send_accept", 128'(ok), 128'(1));
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_result(output logic [127:0] d, output int lat);
        bit got;
        got = 1'b0; lat = 0;
        for (int t = 0; t < 64 && !got; t++) begin
            @(posedge clk); lat++;
            @(negedge clk); got = out_valid;
        end
        chk("result_arrives", 128'(got), 128'(1));
        d = out_data;
    endtask

    initial begin : main
        logic [127:0] d, e, orig, y1, y2;
        int lat;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inv = 1'b0; in_data = '0; out_ready = 1'b1;
        build_tables();
        chk("pin_s00", 128'(fsb[8'h00]), 128'(8'h63));
        chk("pin_s53", 128'(fsb[8'h53]), 128'(8'hed));
        chk("pin_sff", 128'(fsb[8'hff]), 128'(8'h16));
        chk("pin_i52", 128'(isb[8'h52]), 128'(8'h48));
        chk("pin_ied", 128'(isb[8'hed]), 128'(8'h53));
        @(posedge clk); #1 cmp_en = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_out_data", out_data, 128'h0);
        @(posedge clk); #1 rst_n = 1'b1;

        // FIPS-197 SubBytes vector with exact latency
        send(128'h00112233445566778899aabbccddeeff, 1'b0);
        for (int i = 1; i <= NL; i++) begin
            @(posedge clk); @(negedge clk);
            chk($sformatf("t1_valid_c%0d", i), 128'(out_valid), 128'(i == NL));
        end
        chk("t1_fips", out_data, 128'h638293c31bfc33f5c4eeacea4bc12816);
        chk("t1_model", subst(128'h00112233445566778899aabbccddeeff, 1'b0),
            128'h638293c31bfc33f5c4eeacea4bc12816);
        @(posedge clk); #1;

        send({16{8'h52}}, 1'b1); wait_result(d, lat);
        chk("t2_inv52", d, {16{8'h48}});
        chk("t2_lat", 128'(lat), 128'(NL));
        @(posedge clk); #1;
        send({16{8'hed}}, 1'b1); wait_result(d, lat);
        chk("t2_inved", d, {16{8'h53}});
        @(posedge clk); #1;

        for (int n = 0; n < 100; n++) begin
            orig = {$urandom, $urandom, $urandom, $urandom};
            send(orig, 1'b0); wait_result(d, lat);
            chk("rt4_fwd_lat", 128'(lat), 128'(NL));
            chk("rt4_fwd", d, subst(orig, 1'b0));
            @(posedge clk); #1;
            send(d, 1'b1); wait_result(e, lat);
            chk("rt4_inv_lat", 128'(lat), 128'(NL));
            chk("rt4_inv", e, orig);
            @(posedge clk); #1;
        end

        // Held result under backpressure, then same-cycle reload
        out_ready = 1'b0;
        y1 = {$urandom, $urandom, $urandom, $urandom};
        y2 = {$urandom, $urandom, $urandom, $urandom};
        send(y1, 1'b0); wait_result(d, lat);
        chk("t4_result", d, subst(y1, 1'b0));
        @(posedge clk); #1 in_valid = 1'b1; in_data = y2; in_inv = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t4_hold_valid", 128'(out_valid), 128'(1));
            chk("t4_hold_data", out_data, d);
            chk("t4_hold_in_ready", 128'(in_ready), 128'(0));
            @(posedge clk);
        end
        #1 out_ready = 1'b1;
        @(negedge clk); chk("t4_in_ready_follows", 128'(in_ready), 128'(1));
        @(posedge clk); #1 in_valid = 1'b0;
        chk("t4_no_gap_busy", 128'(busy), 128'(1));
        chk("t4_no_gap_valid", 128'(out_valid), 128'(0));
        wait_result(d, lat);
        chk("t4_b2b_lat", 128'(lat), 128'(NL));
        chk("t4_b2b_data", d, subst(y2, 1'b0));
        @(posedge clk); #1;

        // Mode toggled during RUN must be ignored
        y1 = {$urandom, $urandom, $urandom, $urandom};
        send(y1, 1'b1);
        for (int i = 0; i < NL; i++) begin
            in_inv = ~in_inv; @(posedge clk); #1;
        end
        @(negedge clk);
        chk("t5_valid", 128'(out_valid), 128'(1));
        chk("t5_mode", out_data, subst(y1, 1'b1));
        @(posedge clk); #1;

        // Asynchronous reset in RUN cycle 2
        send({$urandom, $urandom, $urandom, $urandom}, 1'b0);
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        chk("t6_arst_in_ready", 128'(in_ready), 128'(1));
        chk("t6_arst_out_valid", 128'(out_valid), 128'(0));
        chk("t6_arst_busy", 128'(busy), 128'(0));
        chk("t6_arst_out_data", out_data, 128'h0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Flush in RUN with a competing in_valid
        send({$urandom, $urandom, $urandom, $urandom}, 1'b0);
        flush = 1'b1; in_valid = 1'b1; in_data = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("t6_flush_busy", 128'(busy), 128'(0));
        chk("t6_flush_in_ready", 128'(in_ready), 128'(1));
        for (int i = 0; i < 8; i++) begin
            chk("t6_flush_no_valid", 128'(out_valid), 128'(0));
            @(negedge clk);
        end

        for (int t = 0; t < 20000 && gen_done < 4; t++) @(posedge clk);
        chk("lanes_instances_done", 128'(gen_done), 128'(4));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Round trips on the other legal lane counts
    for (genvar g = 0; g < 4; g++) begin : g_lanes
        localparam int LG = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16;
        logic         grst_n, gv, grdy, gi, gov, gbusy;
        logic [127:0] gd, gq;

        aes_sbox_engine #(.NBYTES(16), .LANES(LG)) u_dut (
            .clk(clk), .rst_n(grst_n), .flush(1'b0), .in_valid(gv), .in_ready(grdy),
            .in_inv(gi), .in_data(gd), .out_valid(gov), .out_ready(1'b1),
            .out_data(gq), .busy(gbusy)
        );

        initial begin : drv
            logic [127:0] orig, cur;
            bit r, ok, got;
            int lat;
            grst_n = 1'b0; gv = 1'b0; gi = 1'b0; gd = '0;
            repeat (3) @(posedge clk);
            #1 grst_n = 1'b1;
            for (int n = 0; n < 100; n++) begin
                orig = {$urandom, $urandom, $urandom, $urandom};
                cur  = orig;
                for (int p = 0; p < 2; p++) begin
                    gv = 1'b1; gd = cur; gi = (p == 1); ok = 1'b0;
                    for (int t = 0; t < 64 && !ok; t++) begin
                        @(negedge clk); r = grdy;
                        @(posedge clk); ok = r;
                    end
                    #1 gv = 1'b0;
                    chk($sformatf("rt%0d_busy", LG), 128'(gbusy), 128'(1));
                    lat = 0; got = 1'b0;
                    for (int t = 0; t < 64 && !got; t++) begin
                        @(posedge clk); lat++;
                        @(negedge clk); got = gov;
                    end
                    chk($sformatf("rt%0d_lat", LG), 128'(lat), 128'(16 / LG));
                    chk($sformatf("rt%0d_data", LG), gq, (p == 0) ? subst(orig, 1'b0) : orig);
                    cur = gq;
                    @(posedge clk); #1;
                end
            end
            gen_done++;
        end
    end

endmodule
